c499_sec_encoder: RTL and testbench
===================================

// Module: c499_sec_encoder
// PURPOSE
// Pipelined check-bit generator for the c499 32-bit single-error-correcting (SEC) decoder.
// Produces the 8 check bits and the enable that the decoder needs to return a zero syndrome.
// Sits upstream of the decoder: data plus check bits are written to storage or a link, then
// read back through the decoder. Also counts encoded words and injects faults for
// decoder/obfuscation benches.
// PARAMETERS
// PIPE_STAGES  2   pipeline depth; legal values 1 or 2. With 1, the parity and combine terms share one register stage.
// CNT_W        16  width of the encoded-word counter
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous active-low reset
// in_valid   in   1      input word valid
// in_ready   out  1      encoder can accept a word
// in_data    in   32     data word; d[k]=in_data[k] maps to decoder input N(1+4k)
// in_flip    in   40     fault mask sampled with the word; [31:0] data, [39:32] check
// out_valid  out  1      encoded word valid
// out_ready  in   1      downstream accepts the word
// out_data   out  32     data after the fault mask, maps to N1..N125
// out_chk    out  8      check bits after the fault mask; chk[i] maps to N(129+i)
// out_en     out  1      check enable (decoder N137); 1 whenever out_valid=1
// word_cnt   out  CNT_W  number of accepted output transfers, wraps
// BEHAVIOUR
// - Reset (async assert, sync deassert): every stage valid=0.
//   out_data=0, out_chk=0, out_en=0, out_valid=0, word_cnt=0.
//   in_ready=1 from the first clock edge after release.
// - Handshake: a transfer occurs when valid&&ready is sampled at a clk edge.
//   Once out_valid is high, out_valid and out_* stay stable until out_ready.
//   No combinational path from in_valid to out_valid.
// - in_ready = !s1_valid || (s1 advances this cycle). Full throughput of 1 word/clk.
//   out_ready may combinationally affect in_ready.
// - Stage 1 registers:
//   - Group parities P[j] = ^d[4j+3:4j], j=0..7.
//   - Column parities:
//     - C[c]   = d[c]^d[c+4]^d[c+8]^d[c+12], c=0..3.
//     - C[4+c] = d[16+c]^d[20+c]^d[24+c]^d[28+c].
//   - The data word and in_flip.
// - Stage 2 combine:
//   - chk0=C0^P4^P5   chk1=C1^P6^P7   chk2=C2^P4^P6   chk3=C3^P5^P7
//   - chk4=C4^P0^P1   chk5=C5^P2^P3   chk6=C6^P0^P2   chk7=C7^P1^P3
//   - Output registers take out_data = d ^ flip[31:0] and out_chk = chk ^ flip[39:32].
//   - out_en = 1.
// - Latency: 2 cycles from input transfer to out_valid when unstalled (1 if PIPE_STAGES=1).
// - Backpressure: when out_valid && !out_ready, both stages hold. in_ready falls only when s1 is full and cannot advance.
//   No word is dropped or duplicated. A simultaneous out transfer and s1 advance in the same cycle is legal.
// - word_cnt increments on every output transfer, wraps 2^CNT_W-1 -> 0, and is unaffected by stalls.
// - Reset mid-operation discards all in-flight words; nothing is replayed.
// - Contract: with in_flip=0, the c499 decoder fed {out_data,out_chk,out_en} outputs out_data unchanged.
//   A single-bit flip in [31:0] is corrected by the decoder.
// TESTING
// 1. Reset mid-stream with 2 words in flight -> out_valid=0 and word_cnt=0 immediately (async).
//    No stale word appears after release.
// 2. in_data=0x00000000, flip=0 -> out_chk=0x00 two cycles later, out_en=1.
//    in_data=0xFFFFFFFF -> out_chk=0x00.
// 3. in_data=0x00000001 -> out_chk=0x51.
//    in_data=0x80000000 -> out_chk=0x8A.
//    Both fed back-to-back with out_ready=1 -> outputs on consecutive cycles, in order.
// 4. Stream 8 words, hold out_ready=0 for 5 cycles:
//    - in_ready drops after 2 accepted words.
//    - out_* stay stable through the stall.
//    - All 8 words emerge in order, word_cnt=8.
// 5. in_data=0x00000001, in_flip=1<<0 -> out_data=0x00000000, out_chk=0x51.
//    The decoder model restores 0x00000001.
//    in_flip=1<<32 -> out_chk=0x50.
// 6. Random data, 10k words, random in_valid and out_ready -> encoder plus c499 decoder
//    round-trip equals input. word_cnt matches the transfer count mod 2^CNT_W.

Source files
------------

// File: rtl/c499_sec_encoder.sv
// c499_sec_encoder: pipelined check-bit generator for the c499 32-bit SEC decoder.
// Stage 1 registers group/column parities, the data word and the fault mask.
// Stage 2 combines parities into 8 check bits and applies the fault mask.
// A valid/ready handshake runs on both sides, and a counter tracks output transfers.
module c499_sec_encoder #(
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [39:0]      in_flip,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_chk,
  output logic             out_en,
  output logic [CNT_W-1:0] word_cnt
);

  // Group parities: P[j] covers d[4j+3:4j]
  function automatic logic [7:0] grp_par(input logic [31:0] d);
    logic [7:0] p;
    p = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      p[j] = ^d[4*j +: 4];
    end
    return p;
  endfunction

  // Column parities: columns within the low and high 16-bit halves
  function automatic logic [7:0] col_par(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      c[i]     = d[i]      ^ d[i+4]  ^ d[i+8]  ^ d[i+12];
      c[4 + i] = d[16 + i] ^ d[20+i] ^ d[24+i] ^ d[28+i];
    end
    return c;
  endfunction

  // Combine parities into the check bits expected by the decoder
  function automatic logic [7:0] combine(input logic [7:0] p, input logic [7:0] c);
    logic [7:0] k;
    k[0] = c[0] ^ p[4] ^ p[5];
    k[1] = c[1] ^ p[6] ^ p[7];
    k[2] = c[2] ^ p[4] ^ p[6];
    k[3] = c[3] ^ p[5] ^ p[7];
    k[4] = c[4] ^ p[0] ^ p[1];
    k[5] = c[5] ^ p[2] ^ p[3];
    k[6] = c[6] ^ p[0] ^ p[2];
    k[7] = c[7] ^ p[1] ^ p[3];
    return k;
  endfunction

  logic        ready_en;
  logic        out_can_load;
  logic        out_load;
  logic        src_valid;
  logic [31:0] load_data;
  logic [39:0] load_flip;
  logic [7:0]  load_p;
  logic [7:0]  load_c;

  assign out_can_load = !out_valid || out_ready;
  assign out_load     = src_valid && out_can_load;

  // Input side stays closed until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one_stage
      // Parity and combine share the output register stage
      assign src_valid = in_valid && ready_en;
      assign in_ready  = ready_en && out_can_load;
      assign load_data = in_data;
      assign load_flip = in_flip;
      assign load_p    = grp_par(in_data);
      assign load_c    = col_par(in_data);
    end else begin : g_two_stage
      logic        s1_valid;
      logic [31:0] s1_data;
      logic [39:0] s1_flip;
      logic [7:0]  s1_p;
      logic [7:0]  s1_c;
      logic        s1_load;

      // s1 frees up in the same cycle it hands its word to the output stage
      assign in_ready  = ready_en && (!s1_valid || out_can_load);
      assign s1_load   = in_valid && in_ready;
      assign src_valid = s1_valid;
      assign load_data = s1_data;
      assign load_flip = s1_flip;
      assign load_p    = s1_p;
      assign load_c    = s1_c;

      // Stage 1: capture word, mask and parities
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_data  <= '0;
          s1_flip  <= '0;
          s1_p     <= '0;
          s1_c     <= '0;
        end else if (s1_load) begin
          s1_valid <= 1'b1;
          s1_data  <= in_data;
          s1_flip  <= in_flip;
          s1_p     <= grp_par(in_data);
          s1_c     <= col_par(in_data);
        end else if (out_can_load) begin
          s1_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // Output stage: combine check bits, apply fault mask, hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chk   <= '0;
      out_en    <= 1'b0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      out_data  <= load_data ^ load_flip[31:0];
      out_chk   <= combine(load_p, load_c) ^ load_flip[39:32];
      out_en    <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_en    <= 1'b0;
    end
  end

  // Count accepted output transfers, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      word_cnt <= '0;
    else if (out_valid && out_ready) word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Testbench for c499_sec_encoder: directed scenarios plus a randomized stream
// checked against an H-matrix reference model and a single-error-correcting decoder model.
module tb_c499_sec_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [39:0] in_flip = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_chk;
  logic        out_en;
  logic [15:0] word_cnt;

  c499_sec_encoder #(.PIPE_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flip(in_flip),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chk(out_chk), .out_en(out_en), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] orig;
    logic [31:0] data;
    logic [7:0]  chk;
  } exp_t;
  exp_t exp_q[$];

  logic        obs_acc_in, obs_acc_out, obs_valid, obs_en, obs_in_ready;
  logic [31:0] obs_data;
  logic [7:0]  obs_chk;

  // Check-bit signature of data bit k: its column bit plus two group bits
  function automatic logic [7:0] hcol(input int k);
    logic [7:0] m;
    int j, col;
    j   = k / 4;
    col = (k % 4) + 4 * (k / 16);
    m = '0;
    m[col] = 1'b1;
    if (j < 4) begin
      m[4 + j / 2] = 1'b1;
      m[6 + j % 2] = 1'b1;
    end else begin
      m[(j - 4) / 2] = 1'b1;
      m[2 + j % 2]   = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [7:0] enc(input logic [31:0] d);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < 32; k++) if (d[k]) s ^= hcol(k);
    return s;
  endfunction

  function automatic logic [31:0] dec(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [31:0] r;
    syn = enc(d) ^ c;
    r = d;
    for (int k = 0; k < 32; k++) if (syn != 8'h00 && hcol(k) == syn) r[k] = ~r[k];
    return r;
  endfunction

  // One clock: drive at negedge, observe settled outputs, record accepted inputs
  task automatic step(input logic iv, input logic [31:0] d, input logic [39:0] f, input logic ordy);
    @(negedge clk);
    in_valid = iv; in_data = d; in_flip = f; out_ready = ordy;
    #1;
    obs_in_ready = in_ready;
    obs_valid    = out_valid;
    obs_data     = out_data;
    obs_chk      = out_chk;
    obs_en       = out_en;
    obs_acc_in   = iv && in_ready;
    obs_acc_out  = out_valid && ordy;
    if (obs_acc_in) exp_q.push_back('{orig: d, data: d ^ f[31:0], chk: enc(d) ^ f[39:32]});
    @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_en, out_data, out_chk, word_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b en=%b d=%h c=%h cnt=%0d expected all zero",
               out_valid, out_en, out_data, out_chk, word_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_zero_ones();
    step(1'b1, 32'h0000_0000, '0, 1'b1);
    step(1'b1, 32'hFFFF_FFFF, '0, 1'b1);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early: out_valid got %b expected 0", obs_valid);
    end
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (obs_valid !== 1'b1 || obs_en !== 1'b1 || obs_data !== 32'h0 || obs_chk !== 8'h00) begin
      errors++;
      $display("FAIL zero_word: got v=%b en=%b d=%h c=%h expected v=1 en=1 d=00000000 c=00",
               obs_valid, obs_en, obs_data, obs_chk);
    end
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 32'hFFFF_FFFF || obs_chk !== 8'h00) begin
      errors++;
      $display("FAIL ones_word: got v=%b d=%h c=%h expected v=1 d=ffffffff c=00",
               obs_valid, obs_data, obs_chk);
    end
    step(1'b0, '0, '0, 1'b1);
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h0000_0001, '0, 1'b1);
    step(1'b1, 32'h8000_0000, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 32'h0000_0001 || obs_chk !== 8'h51) begin
      errors++;
      $display("FAIL b2b_first: got v=%b d=%h c=%h expected v=1 d=00000001 c=51",
               obs_valid, obs_data, obs_chk);
    end
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 32'h8000_0000 || obs_chk !== 8'h8A) begin
      errors++;
      $display("FAIL b2b_second: got v=%b d=%h c=%h expected v=1 d=80000000 c=8a",
               obs_valid, obs_data, obs_chk);
    end
    step(1'b0, '0, '0, 1'b1);
    exp_q.delete();
  endtask

  task automatic test_stall();
    logic [31:0] words[8];
    int idx, nout;
    logic dropped, prev_stall;
    logic [31:0] prev_data;
    logic [7:0]  prev_chk;
    exp_t e;
    apply_reset();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    idx = 0; nout = 0; dropped = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_chk = '0;
    for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
      step(idx < 8, (idx < 8) ? words[idx] : 32'h0, '0, cyc >= 5);
      if (!obs_in_ready && !dropped) begin
        dropped = 1'b1;
        checks++;
        if (idx !== 2) begin
          errors++; $display("FAIL stall_ready_drop: accepted %0d before drop expected 2", idx);
        end
      end
      if (prev_stall) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== prev_data || obs_chk !== prev_chk) begin
          errors++;
          $display("FAIL stall_stable: got v=%b d=%h c=%h expected v=1 d=%h c=%h",
                   obs_valid, obs_data, obs_chk, prev_data, prev_chk);
        end
      end
      prev_stall = obs_valid && (cyc < 5);
      prev_data  = obs_data;
      prev_chk   = obs_chk;
      if (obs_acc_in) idx++;
      if (obs_acc_out) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_data !== e.data || obs_chk !== e.chk) begin
          errors++;
          $display("FAIL stall_order[%0d]: got d=%h c=%h expected d=%h c=%h",
                   nout, obs_data, obs_chk, e.data, e.chk);
        end
        nout++;
      end
    end
    checks++;
    if (!dropped || nout != 8) begin
      errors++; $display("FAIL stall_complete: dropped=%b outputs=%0d expected dropped=1 outputs=8", dropped, nout);
    end
    @(negedge clk);
    checks++;
    if (word_cnt !== 16'd8) begin
      errors++; $display("FAIL stall_word_cnt: got %0d expected 8", word_cnt);
    end
  endtask

  task automatic test_flip();
    step(1'b1, 32'h0000_0001, 40'h1, 1'b1);
    step(1'b1, 32'h0000_0001, 40'h1 << 32, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (obs_data !== 32'h0 || obs_chk !== 8'h51 || dec(obs_data, obs_chk) !== 32'h1) begin
      errors++;
      $display("FAIL flip_data: got d=%h c=%h decoded=%h expected d=00000000 c=51 decoded=00000001",
               obs_data, obs_chk, dec(obs_data, obs_chk));
    end
    step(1'b0, '0, '0, 1'b1);
    checks++;
    if (obs_data !== 32'h1 || obs_chk !== 8'h50) begin
      errors++;
      $display("FAIL flip_chk: got d=%h c=%h expected d=00000001 c=50", obs_data, obs_chk);
    end
    step(1'b0, '0, '0, 1'b1);
    exp_q.delete();
  endtask

  task automatic test_random();
    int nout;
    logic [39:0] f;
    exp_t e;
    apply_reset();
    nout = 0;
    for (int cyc = 0; cyc < 60000 && nout < 10000; cyc++) begin
      f = '0;
      if ($urandom_range(0, 3) == 0) f = 40'h1 << $urandom_range(0, 39);
      step($urandom_range(0, 9) < 7, $urandom, f, $urandom_range(0, 9) < 7);
      if (obs_acc_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: output d=%h with nothing expected", obs_data);
        end else begin
          e = exp_q.pop_front();
          if (obs_data !== e.data || obs_chk !== e.chk || obs_en !== 1'b1 ||
              dec(obs_data, obs_chk) !== e.orig) begin
            errors++;
            $display("FAIL rand_word[%0d]: got d=%h c=%h en=%b dec=%h expected d=%h c=%h en=1 dec=%h",
                     nout, obs_data, obs_chk, obs_en, dec(obs_data, obs_chk), e.data, e.chk, e.orig);
          end
        end
        nout++;
      end
    end
    checks++;
    if (nout != 10000) begin
      errors++; $display("FAIL rand_count: got %0d outputs expected 10000", nout);
    end
    @(negedge clk);
    checks++;
    if (word_cnt !== 16'(nout)) begin
      errors++; $display("FAIL rand_word_cnt: got %0d expected %0d", word_cnt, 16'(nout));
    end
  endtask

  task automatic test_midreset();
    step(1'b1, 32'h1234_5678, '0, 1'b0);
    step(1'b1, 32'h9ABC_DEF0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    #2;
    checks++;
    if (out_valid !== 1'b1 || word_cnt === 16'd0) begin
      errors++; $display("FAIL midreset_pre: got v=%b cnt=%0d expected v=1 cnt nonzero", out_valid, word_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 16'd0) begin
      errors++; $display("FAIL midreset_async: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, word_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b1);
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_stale[%0d]: out_valid got %b expected 0", i, obs_valid);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_ones();
    test_back_to_back();
    test_stall();
    test_flip();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
